// File: rtl/adder_tree_acc_pkg.sv
// Shared helpers and types for the adder-tree accumulator.
package adder_tree_acc_pkg;

  // Sideband bits that travel alongside the data through every stage
  typedef struct packed {
    logic valid;
    logic last;
  } sb_t;

  // Node count at tree stage k (stage 0 = the raw operands)
  function automatic int unsigned stage_nodes(input int unsigned n, input int unsigned k);
    int unsigned m;
    m = n;
    for (int unsigned i = 0; i < k; i++) begin
      m = (m + 1) / 2;
    end
    return m;
  endfunction

  // Result width: operand width + tree growth + accumulation headroom
  function automatic int unsigned out_width(input int unsigned w, input int unsigned n,
                                            input int unsigned g);
    return w + $clog2(n) + g;
  endfunction

endpackage

// File: rtl/adder_tree_node.sv
// One registered node of the reduction tree: adds two children, or passes a lone child
// through with one bit of extension.
module adder_tree_node #(
  parameter int unsigned IN_W   = 32,
  parameter bit          SIGNED = 1'b1,
  parameter bit          PAIRED = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [IN_W-1:0] a,
  input  logic [IN_W-1:0] b,
  output logic [IN_W:0]   y
);

  logic [IN_W:0] a_ext;
  logic [IN_W:0] b_ext;
  logic [IN_W:0] y_d;

  // Extend children by one bit, then add or pass through
  always_comb begin
    a_ext = {SIGNED && a[IN_W-1], a};
    b_ext = {SIGNED && b[IN_W-1], b};
    y_d   = PAIRED ? a_ext + b_ext : a_ext;
  end

  // Node register, frozen while the pipeline is stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y <= '0;
    end else if (en) begin
      y <= y_d;
    end
  end

endmodule

// File: rtl/adder_tree_acc.sv
// Pipelined reduction tree over INPUT_NUM operands followed by a beat-group accumulator.
// The whole pipeline stalls while a result is waiting for the downstream stage.
module adder_tree_acc
  import adder_tree_acc_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned INPUT_NUM  = 9,
  parameter bit          SIGNED     = 1'b1,
  parameter int unsigned ACC_GROWTH = 8,
  localparam int unsigned OUT_WIDTH = out_width(WIDTH, INPUT_NUM, ACC_GROWTH)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic                                in_last,
  input  logic [INPUT_NUM-1:0][WIDTH-1:0]     indata,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [OUT_WIDTH-1:0]                out_data
);

  localparam int unsigned S     = $clog2(INPUT_NUM);
  localparam int unsigned SUM_W = WIDTH + S;

  logic                 en;
  sb_t                  sb_in;
  sb_t                  sb_q [S];
  logic [SUM_W-1:0]     tree_sum;
  logic [OUT_WIDTH-1:0] sum_ext;
  logic [OUT_WIDTH-1:0] acc_d;
  logic [OUT_WIDTH-1:0] acc_q;
  logic [OUT_WIDTH-1:0] out_data_q;
  logic                 grp_open_q;
  logic                 out_valid_q;

  // Hold everything while an unaccepted result sits at the output
  assign en        = !(out_valid_q && !out_ready);
  assign in_ready  = en;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  // Tree stages: stage k turns NI nodes of width WIDTH+k-1 into NO nodes one bit wider
  for (genvar k = 1; k <= S; k++) begin : gen_stage
    localparam int unsigned NI = stage_nodes(INPUT_NUM, k - 1);
    localparam int unsigned NO = stage_nodes(INPUT_NUM, k);
    localparam int unsigned IW = WIDTH + k - 1;

    logic [NI-1:0][IW-1:0] din;
    logic [NO-1:0][IW:0]   dout;

    if (k == 1) begin : gen_src_in
      assign din = indata;
    end else begin : gen_src_prev
      assign din = gen_stage[k-1].dout;
    end

    for (genvar j = 0; j < NO; j++) begin : gen_node
      localparam bit PAIRED = (2 * j + 1 < NI);
      logic [IW-1:0] b_in;

      if (PAIRED) begin : gen_pair
        assign b_in = din[2*j+1];
      end else begin : gen_lone
        assign b_in = '0;
      end

      adder_tree_node #(
        .IN_W  (IW),
        .SIGNED(SIGNED),
        .PAIRED(PAIRED)
      ) u_node (
        .clk(clk),
        .rst(rst),
        .en (en),
        .a  (din[2*j]),
        .b  (b_in),
        .y  (dout[j])
      );
    end
  end

  assign tree_sum = gen_stage[S].dout[0];

  // A beat's last flag only counts when the beat itself is valid
  always_comb begin
    sb_in       = '0;
    sb_in.valid = in_valid;
    sb_in.last  = in_valid && in_last;
  end

  // Sideband shift register running in lock-step with the tree stages
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < S; k++) begin
        sb_q[k] <= '0;
      end
    end else if (en) begin
      sb_q[0] <= sb_in;
      for (int k = 1; k < S; k++) begin
        sb_q[k] <= sb_q[k-1];
      end
    end
  end

  // Widen the tree sum and add it to the open group (or start a new one)
  always_comb begin
    if (SIGNED) begin
      sum_ext = OUT_WIDTH'($signed(tree_sum));
    end else begin
      sum_ext = OUT_WIDTH'(tree_sum);
    end
    acc_d = (grp_open_q ? acc_q : '0) + sum_ext;
  end

  // Accumulator and output register; a last beat publishes the group total
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q       <= '0;
      grp_open_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (en) begin
      // en implies the output is empty or being taken this cycle
      out_valid_q <= sb_q[S-1].valid && sb_q[S-1].last;
      if (sb_q[S-1].valid) begin
        acc_q      <= acc_d;
        grp_open_q <= !sb_q[S-1].last;
        if (sb_q[S-1].last) begin
          out_data_q <= acc_d;
        end
      end
    end
  end

endmodule

// File: tb/tb_adder_tree_acc.sv
// Scoreboard bench for adder_tree_acc: directed cases on 9- and 5-input instances plus
// randomized group traffic on several tree sizes against an arithmetic reference model.
module tb_adder_tree_acc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst  = 1'b1;
  logic rst9 = 1'b1;

  int n_cmp    = 0;
  int n_err    = 0;
  int done_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int cfg_n(input int g);
    case (g)
      0:       return 2;
      1:       return 3;
      2:       return 8;
      3:       return 9;
      default: return 16;
    endcase
  endfunction

  // ---------------- 9-input signed instance (directed) ----------------
  logic              v9, rdy9, l9, ov9, ordy9;
  logic [8:0][31:0]  d9;
  logic [43:0]       od9;
  logic [43:0]       q9[$];

  adder_tree_acc #(
    .WIDTH(32), .INPUT_NUM(9), .SIGNED(1'b1), .ACC_GROWTH(8)
  ) u_dut9 (
    .clk(clk), .rst(rst9), .in_valid(v9), .in_ready(rdy9), .in_last(l9), .indata(d9),
    .out_valid(ov9), .out_ready(ordy9), .out_data(od9)
  );

  always @(negedge clk) begin
    #2;
    if (ov9 && ordy9) begin
      if (q9.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL d9_extra: got unexpected result %0h, expected none", od9);
      end else begin
        check("d9_result", od9, q9.pop_front());
      end
    end
  end

  // Present one beat at the falling edge; when valid, wait until it is accepted
  task automatic drv9(input logic v, input logic l, input logic [8:0][31:0] d);
    int t;
    @(negedge clk);
    v9 = v;
    l9 = l;
    d9 = d;
    if (v) begin
      t = 0;
      #1;
      while (!rdy9 && t < 50) begin
        @(negedge clk);
        #1;
        t++;
      end
      check("d9_accept", rdy9, 1);
    end
  endtask

  task automatic drain9(input string name);
    int t;
    t = 0;
    while (q9.size() != 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check(name, q9.size(), 0);
  endtask

  initial begin : dir9
    logic [8:0][31:0] d;
    logic [43:0]      e;
    int               first;
    int               hi;
    int               t;
    v9    = 1'b0;
    l9    = 1'b0;
    d9    = '0;
    ordy9 = 1'b1;
    repeat (2) @(negedge clk);
    rst9 = 1'b0;
    #1;
    check("rst_out_valid", ov9, 0);
    check("rst_out_data", od9, 0);
    check("rst_in_ready", rdy9, 1);

    // 1..9 in one beat: 45, five register stages, one-cycle pulse
    for (int j = 0; j < 9; j++) d[j] = 32'(j + 1);
    q9.push_back(44'd45);
    drv9(1'b1, 1'b1, d);
    first = 0;
    hi    = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      v9 = 1'b0;
      #1;
      if (ov9) begin
        if (first == 0) first = k;
        hi++;
      end
    end
    check("latency", first, 5);
    check("valid_pulse", hi, 1);
    drain9("d9_drain_single");

    // Three all-ones beats, bubble (with stray last) after the first: -27
    d = {9{32'hFFFF_FFFF}};
    e = -44'sd27;
    q9.push_back(e);
    drv9(1'b1, 1'b0, d);
    drv9(1'b0, 1'b1, {9{32'h1234_5678}});
    drv9(1'b1, 1'b0, d);
    drv9(1'b1, 1'b1, d);
    drv9(1'b0, 1'b0, d);
    drain9("d9_drain_neg");

    // Back-to-back single-beat groups of 10 and 20 with a three-cycle output stall
    d = '0;
    d[0] = 32'd10;
    q9.push_back(44'd10);
    q9.push_back(44'd20);
    drv9(1'b1, 1'b1, d);
    d[0] = 32'd20;
    drv9(1'b1, 1'b1, d);
    @(negedge clk);
    v9 = 1'b0;
    t = 0;
    while (!ov9 && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("stall_first_valid", ov9, 1);
    ordy9 = 1'b0;
    #1;
    check("stall_in_ready", rdy9, 0);
    check("stall_hold_data", od9, 10);
    repeat (2) begin
      @(negedge clk);
      #1;
      check("stall_in_ready", rdy9, 0);
      check("stall_hold_valid", ov9, 1);
      check("stall_hold_data", od9, 10);
    end
    @(negedge clk);
    ordy9 = 1'b1;
    @(negedge clk);
    #1;
    check("after_stall_valid", ov9, 1);
    check("after_stall_data", od9, 20);
    drain9("d9_drain_stall");

    // Reset after two beats of a three-beat group; next group must start clean
    d = {9{32'd5}};
    drv9(1'b1, 1'b0, d);
    drv9(1'b1, 1'b0, d);
    @(negedge clk);
    v9   = 1'b0;
    rst9 = 1'b1;
    #1;
    check("midrst_valid", ov9, 0);
    check("midrst_data", od9, 0);
    @(negedge clk);
    rst9 = 1'b0;
    d    = '0;
    d[3] = 32'd7;
    q9.push_back(44'd7);
    drv9(1'b1, 1'b1, d);
    drv9(1'b0, 1'b0, d);
    drain9("d9_drain_rst");
    done_cnt++;
  end

  // ---------------- 5-input unsigned instance (directed) ----------------
  logic              v5, rdy5, l5, ov5, ordy5;
  logic [4:0][31:0]  d5;
  logic [42:0]       od5;
  logic [42:0]       q5[$];

  adder_tree_acc #(
    .WIDTH(32), .INPUT_NUM(5), .SIGNED(1'b0), .ACC_GROWTH(8)
  ) u_dut5 (
    .clk(clk), .rst(rst), .in_valid(v5), .in_ready(rdy5), .in_last(l5), .indata(d5),
    .out_valid(ov5), .out_ready(ordy5), .out_data(od5)
  );

  always @(negedge clk) begin
    #2;
    if (ov5 && ordy5) begin
      if (q5.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL d5_extra: got unexpected result %0h, expected none", od5);
      end else begin
        check("d5_result", od5, q5.pop_front());
      end
    end
  end

  initial begin : dir5
    int t;
    v5    = 1'b0;
    l5    = 1'b0;
    d5    = '0;
    ordy5 = 1'b1;
    @(negedge rst);
    // 20 copies of 2^32-1 must not wrap
    q5.push_back(43'd85899345900);
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      v5 = 1'b1;
      l5 = (b == 3);
      d5 = {5{32'hFFFF_FFFF}};
      #1;
      check("d5_in_ready", rdy5, 1);
    end
    @(negedge clk);
    v5 = 1'b0;
    l5 = 1'b0;
    t  = 0;
    while (q5.size() != 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("d5_drain", q5.size(), 0);
    done_cnt++;
  end

  // ---------------- randomized instances ----------------
  for (genvar g = 0; g < 5; g++) begin : gen_rand
    localparam int N  = cfg_n(g);
    localparam bit SG = (g % 2 == 0);
    localparam int OW = 32 + $clog2(N) + 8;

    logic             iv, ir, il, ov, ordy;
    logic [N-1:0][31:0] id;
    logic [OW-1:0]    od;
    logic [OW-1:0]    q[$];

    adder_tree_acc #(
      .WIDTH(32), .INPUT_NUM(N), .SIGNED(SG), .ACC_GROWTH(8)
    ) u_dut (
      .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir), .in_last(il), .indata(id),
      .out_valid(ov), .out_ready(ordy), .out_data(od)
    );

    always @(negedge clk) begin
      #2;
      if (ov && ordy) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL rand_n%0d_extra: got unexpected result %0h, expected none", N, od);
        end else begin
          check($sformatf("rand_n%0d", N), 64'(od), 64'(q.pop_front()));
        end
      end
    end

    initial begin : drv
      longint acc;
      longint s;
      int     nb;
      int     t;
      iv   = 1'b0;
      il   = 1'b0;
      id   = '0;
      ordy = 1'b1;
      acc  = 0;
      @(negedge rst);
      for (int grp = 0; grp < 25; grp++) begin
        nb = $urandom_range(1, 6);
        for (int b = 0; b < nb; b++) begin
          @(negedge clk);
          ordy = ($urandom_range(0, 3) != 0);
          while ($urandom_range(0, 3) == 0) begin
            iv = 1'b0;
            il = 1'($urandom);
            id = {N{$urandom}};
            @(negedge clk);
            ordy = ($urandom_range(0, 3) != 0);
          end
          s = 0;
          for (int j = 0; j < N; j++) begin
            id[j] = $urandom;
            if (SG) s += longint'($signed(id[j]));
            else    s += longint'(id[j]);
          end
          iv = 1'b1;
          il = (b == nb - 1);
          #1;
          t = 0;
          while (!ir && t < 200) begin
            @(negedge clk);
            ordy = ($urandom_range(0, 3) != 0);
            #1;
            t++;
          end
          if (!ir) begin
            n_cmp++;
            n_err++;
            $display("FAIL rand_n%0d_accept: got in_ready 0, expected 1 within 200 cycles", N);
          end
          acc += s;
          if (il) begin
            q.push_back(OW'(acc));
            acc = 0;
          end
        end
      end
      @(negedge clk);
      iv   = 1'b0;
      ordy = 1'b1;
      t    = 0;
      while (q.size() != 0 && t < 100) begin
        @(negedge clk);
        ordy = 1'b1;
        t++;
      end
      check($sformatf("rand_n%0d_drain", N), q.size(), 0);
      done_cnt++;
    end
  end

  initial begin : main
    int t;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    t   = 0;
    while (done_cnt < 7 && t < 20000) begin
      @(negedge clk);
      t++;
    end
    if (done_cnt < 7) begin
      n_cmp++;
      n_err++;
      $display("FAIL timeout: got %0d finished streams, expected 7", done_cnt);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/adder_tree_acc.md
# adder_tree_acc

Pipelined, parametrised reduction tree with beat-group accumulation for the convolution datapath. Each accepted beat carries `INPUT_NUM` products (any count ≥ 2, not only powers of two), which are summed with full width growth. Consecutive beats up to and including an `in_last` beat are accumulated into one result, so a kernel's partial sums over several input channels leave as a single word. The block sits between the multiplier array and the output/writeback stage, with a valid/ready handshake and whole-pipeline stall.

## Interface
- `WIDTH`, 32, width of each input operand
- `INPUT_NUM`, 9, operands per beat, ≥ 2, any integer
- `SIGNED`, 1, 1 = two's-complement operands, 0 = unsigned
- `ACC_GROWTH`, 8, extra accumulator bits, so a group of up to 2^ACC_GROWTH beats cannot overflow
- `OUT_WIDTH`, WIDTH + $clog2(INPUT_NUM) + ACC_GROWTH, derived, not overridable
- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `in_valid`  in  1  beat present
- `in_ready`  out  1  beat accepted when `in_valid && in_ready`
- `in_last`  in  1  final beat of the current accumulation group
- `indata`  in  [INPUT_NUM-1:0][WIDTH-1:0]  operands
- `out_valid`  out  1  result present
- `out_ready`  in  1  downstream accepts result
- `out_data`  out  OUT_WIDTH  group sum

## Operation
- Tree stage k (k = 1..S, S = $clog2(INPUT_NUM)) holds ceil(n_{k-1}/2) registered nodes, with n_0 = INPUT_NUM.
  - A node at stage k is WIDTH+k bits wide.
  - Paired nodes add their two children.
  - An unpaired last node registers its child unchanged, extended by one bit (sign-extended if SIGNED, else zero-extended).
- Every stage carries `valid` and `last` sideband bits alongside its data.
- Accumulator stage (stage S+1):
  - It holds `acc` (OUT_WIDTH bits) and a `grp_open` flag.
  - On a valid tree output: `acc <= (grp_open ? acc : 0) + ext(tree_sum)`.
  - `grp_open` is cleared by the `last` bit and set otherwise.
  - When `last` is set, `out_valid` is set and `out_data` is loaded with the new sum.
- Arithmetic wraps modulo 2^OUT_WIDTH. There is no saturation and no overflow flag.
- A group is one or more beats. A single beat with `in_last=1` gives that beat's sum.
- Bubbles (cycles with `in_valid=0`) inside a group are allowed and do not close the group.
- Stall:
  - `en = !(out_valid && !out_ready)`.
  - When `en=0`, every stage register, `acc`, `grp_open` and `out_data` hold.
  - `in_ready = en`.
- `out_valid` clears on handshake unless a new `last` result loads in the same cycle.

## Timing
- Reset values: `out_valid=0`, `out_data=0`, all stage data/valid/last = 0, `acc=0`, `grp_open=0`, `in_ready=1`.
- `in_ready` is combinational from `out_valid` and `out_ready`.
- Latency with no stall: the last beat accepted at edge t gives `out_valid=1` after edge t+S+1. Examples:
  - INPUT_NUM=9: S=4, latency 5.
  - INPUT_NUM=8: latency 4.
- Throughput is one beat per cycle. Back-to-back groups, including consecutive single-beat groups, need no idle cycle.
- Stall cycles add to the latency one-for-one. No beat is lost or duplicated.
- Output hold: `out_data` is stable while `out_valid && !out_ready`.
- Reset mid-group: the partial group is discarded. The first beat after reset starts a new group.
- Beat with `in_valid=0`: `in_last` and `indata` are ignored.

## Structure
- Package `adder_tree_acc_pkg` holds:
  - function `stage_nodes(n, k)`: node count at stage k.
  - function `out_width(w, n, g)`.
  - typedef for the sideband struct {valid, last}.
- Sub-module `adder_tree_node`:
  - Parameters: IN_W, SIGNED, PAIRED.
  - Ports: `clk`, `rst`, `en`, `a`, `b`, `y` (IN_W+1 bits).
  - Behaviour: registered add or pass-through, with async reset to 0.
- The top level generates one `adder_tree_node` per node per stage, plus the accumulator and handshake logic.

## Test plan
- INPUT_NUM=9, SIGNED=1, `indata` = 1..9, single beat with `in_last=1`, `out_ready=1` -> `out_data=45`, `out_valid` exactly 5 cycles after acceptance, high for 1 cycle.
- INPUT_NUM=9, three beats of all `-1` (WIDTH=32), last on the third, with a one-cycle bubble after beat 1 -> one result, `out_data=-27` sign-extended.
- INPUT_NUM=5, SIGNED=0, every operand 0xFFFFFFFF, 4-beat group -> `out_data = 20*(2^32-1)`, no wrap.
- Two back-to-back single-beat groups (sums 10 and 20), `out_ready=0` for 3 cycles when the first result appears:
  - `in_ready=0` during the stall.
  - Output is 10 held for the 3 cycles, then 20 on the next cycle.
- `rst` asserted after beat 2 of a 3-beat group, then a fresh single beat of sum 7 -> `out_data=7`, no residue from the discarded group.
- Random sweep over INPUT_NUM ∈ {2, 3, 8, 9, 16}, random `in_valid`/`out_ready`, groups of 1-6 beats -> results match a reference model in order.
